// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_if
//  Description : Single-port data bus between the memory pipeline stage and
//                the data memory. Word-addressed, big-endian byte selects,
//                req/ack handshake with a one-cycle ack pulse.
//  Signals     : bus_req   - access request (master)
//                bus_we    - write enable (master)
//                bus_addr  - word-aligned address (master)
//                bus_sel   - byte-lane selects, bit 3 = bits 31:24 (master)
//                bus_wdata - write data, replicated across lanes (master)
//                bus_rdata - read data (slave)
//                bus_ack   - access complete, same-cycle capable (slave)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : MEM pipeline stage. Runs LB/LBU/LH/LHU/LW/SB/SH/SW/LL/SC on
//                a req/ack data bus, extends load data, resolves the LL/SC
//                link bit, requests a pipeline stall while a bus access is
//                outstanding and passes the remaining EX results to MEM/WB.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                ex_*                - EX/MEM register outputs
//                llbit_i, wb_*       - committed link bit and WB forward
//                stall_i             - pipeline stall vector (bit 4 = MEM)
//                bus                 - data bus, master side
//                mem_*               - MEM/WB register inputs
//                stallreq            - hold IF..MEM while bus is busy
//                addr_err            - misaligned access flag
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic [3:0]  ex_op,
  input  wire logic [31:0] ex_mem_addr,
  input  wire logic [31:0] ex_store_data,
  input  wire logic [4:0]  ex_waddr,
  input  wire logic [31:0] ex_wdata,
  input  wire logic        ex_wreg,
  input  wire logic [31:0] ex_hi,
  input  wire logic [31:0] ex_lo,
  input  wire logic        ex_wspreg,
  input  wire logic        ex_wcp0,
  input  wire logic [4:0]  ex_cp0_waddr,
  input  wire logic [31:0] ex_cp0_wdata,
  input  wire logic        llbit_i,
  input  wire logic        wb_watomicreg,
  input  wire logic        wb_atomicreg_wdata,
  input  wire logic [5:0]  stall_i,
  mem_stage_if.master      bus,
  output logic [4:0]       mem_waddr,
  output logic [31:0]      mem_wdata,
  output logic             mem_wreg,
  output logic [31:0]      mem_hi,
  output logic [31:0]      mem_lo,
  output logic             mem_wspreg,
  output logic             mem_watomicreg,
  output logic             mem_atomicreg_wdata,
  output logic             mem_wcp0,
  output logic [4:0]       mem_cp0_waddr,
  output logic [31:0]      mem_cp0_wdata,
  output logic             stallreq,
  output logic             addr_err
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;
  localparam logic [3:0] OP_LL  = 4'd9;
  localparam logic [3:0] OP_SC  = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_rdata;
  logic        w_req;
  logic        w_capture;

  // ---------------------------------------------------------------- decode
  logic w_is_ll, w_is_sc, w_byte, w_half, w_word, w_is_load, w_is_store;
  logic w_misalign, w_link, w_sc_fail, w_need_bus;

  assign w_is_ll    = (ex_op == OP_LL);
  assign w_is_sc    = (ex_op == OP_SC);
  assign w_byte     = (ex_op == OP_LB) || (ex_op == OP_LBU) || (ex_op == OP_SB);
  assign w_half     = (ex_op == OP_LH) || (ex_op == OP_LHU) || (ex_op == OP_SH);
  assign w_word     = (ex_op == OP_LW) || (ex_op == OP_SW) || w_is_ll || w_is_sc;
  assign w_is_load  = (ex_op == OP_LB) || (ex_op == OP_LBU) || (ex_op == OP_LH) ||
                      (ex_op == OP_LHU) || (ex_op == OP_LW) || w_is_ll;
  assign w_is_store = (ex_op == OP_SB) || (ex_op == OP_SH) || (ex_op == OP_SW) || w_is_sc;

  assign w_misalign = (w_half && ex_mem_addr[0]) ||
                      (w_word && (ex_mem_addr[1:0] != 2'b00));

  // The link bit being written in WB this cycle is newer than the committed one.
  assign w_link     = wb_watomicreg ? wb_atomicreg_wdata : llbit_i;
  assign w_sc_fail  = w_is_sc && !w_link;
  assign w_need_bus = (w_is_load || w_is_store) && !w_misalign && !w_sc_fail;

  // Only bit 4 of the stall vector concerns this stage.
  logic w_unused_stall;
  assign w_unused_stall = &{1'b0, stall_i[5], stall_i[3:0]};

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rdata <= 32'h0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) r_rdata <= bus.bus_rdata;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_need_bus) begin
          w_req = 1'b1;
          if (!bus.bus_ack) begin
            w_state_next = WAIT;
          end else if (stall_i[4]) begin
            w_state_next = DONE;
            w_capture    = 1'b1;
          end
        end
      end
      WAIT: begin
        w_req = 1'b1;
        if (bus.bus_ack) begin
          if (stall_i[4]) begin
            w_state_next = DONE;
            w_capture    = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      DONE: begin
        // Result is held from the captured word until MEM is released.
        if (!stall_i[4]) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // ------------------------------------------------------ data formatting
  logic [31:0] w_rword;
  logic [7:0]  w_rbyte;
  logic [15:0] w_rhalf;
  logic [31:0] w_load_data;
  logic [31:0] w_store_data;
  logic [3:0]  w_sel;

  // Once in DONE the bus no longer holds the read word.
  assign w_rword = (r_state == DONE) ? r_rdata : bus.bus_rdata;

  always_comb begin
    w_rbyte = 8'h0;
    case (ex_mem_addr[1:0])
      2'b00:   w_rbyte = w_rword[31:24];
      2'b01:   w_rbyte = w_rword[23:16];
      2'b10:   w_rbyte = w_rword[15:8];
      default: w_rbyte = w_rword[7:0];
    endcase
  end

  assign w_rhalf = ex_mem_addr[1] ? w_rword[15:0] : w_rword[31:16];

  always_comb begin
    w_load_data = w_rword;
    case (ex_op)
      OP_LB:   w_load_data = {{24{w_rbyte[7]}}, w_rbyte};
      OP_LBU:  w_load_data = {24'h0, w_rbyte};
      OP_LH:   w_load_data = {{16{w_rhalf[15]}}, w_rhalf};
      OP_LHU:  w_load_data = {16'h0, w_rhalf};
      default: w_load_data = w_rword;
    endcase
  end

  always_comb begin
    w_sel        = 4'b1111;
    w_store_data = ex_store_data;
    if (w_byte) begin
      w_sel        = 4'b1000 >> ex_mem_addr[1:0];
      w_store_data = {4{ex_store_data[7:0]}};
    end else if (w_half) begin
      w_sel        = ex_mem_addr[1] ? 4'b0011 : 4'b1100;
      w_store_data = {2{ex_store_data[15:0]}};
    end
  end

  // -------------------------------------------------------------- outputs
  logic        w_bus_req;
  logic        w_bus_we;
  logic [31:0] w_bus_addr;
  logic [3:0]  w_bus_sel;
  logic [31:0] w_bus_wdata;

  always_comb begin
    w_bus_req           = 1'b0;
    w_bus_we            = 1'b0;
    w_bus_addr          = 32'h0;
    w_bus_sel           = 4'b0000;
    w_bus_wdata         = 32'h0;
    stallreq            = 1'b0;
    addr_err            = 1'b0;
    mem_waddr           = 5'h0;
    mem_wdata           = 32'h0;
    mem_wreg            = 1'b0;
    mem_hi              = 32'h0;
    mem_lo              = 32'h0;
    mem_wspreg          = 1'b0;
    mem_watomicreg      = 1'b0;
    mem_atomicreg_wdata = 1'b0;
    mem_wcp0            = 1'b0;
    mem_cp0_waddr       = 5'h0;
    mem_cp0_wdata       = 32'h0;
    if (!rst) begin
      w_bus_req     = w_req;
      if (w_req) begin
        w_bus_we    = w_is_store;
        w_bus_addr  = {ex_mem_addr[31:2], 2'b00};
        w_bus_sel   = w_sel;
        w_bus_wdata = w_store_data;
      end
      stallreq      = w_req && !bus.bus_ack;
      addr_err      = w_misalign;
      mem_waddr     = ex_waddr;
      mem_hi        = ex_hi;
      mem_lo        = ex_lo;
      mem_wspreg    = ex_wspreg;
      mem_wcp0      = ex_wcp0;
      mem_cp0_waddr = ex_cp0_waddr;
      mem_cp0_wdata = ex_cp0_wdata;
      mem_wreg      = ex_wreg && !w_misalign;
      mem_wdata     = ex_wdata;
      if (!w_misalign) begin
        if (w_is_load) mem_wdata = w_load_data;
        if (w_is_ll) begin
          mem_watomicreg      = 1'b1;
          mem_atomicreg_wdata = 1'b1;
        end
        if (w_is_sc) begin
          // SC reports success in rt and clears the link on success.
          mem_wdata = {31'h0, w_link};
          if (w_link) mem_watomicreg = 1'b1;
        end
      end
    end
  end

  assign bus.bus_req   = w_bus_req;
  assign bus.bus_we    = w_bus_we;
  assign bus.bus_addr  = w_bus_addr;
  assign bus.bus_sel   = w_bus_sel;
  assign bus.bus_wdata = w_bus_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Directed testbench for mem_stage. Each scenario task drives
//                the EX inputs and the bus response and checks the stage
//                outputs against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ex_op;
  logic [31:0] ex_mem_addr, ex_store_data, ex_wdata, ex_hi, ex_lo, ex_cp0_wdata;
  logic [4:0]  ex_waddr, ex_cp0_waddr;
  logic        ex_wreg, ex_wspreg, ex_wcp0;
  logic        llbit_i, wb_watomicreg, wb_atomicreg_wdata;
  logic [5:0]  stall_i;
  logic [4:0]  mem_waddr, mem_cp0_waddr;
  logic [31:0] mem_wdata, mem_hi, mem_lo, mem_cp0_wdata;
  logic        mem_wreg, mem_wspreg, mem_watomicreg, mem_atomicreg_wdata, mem_wcp0;
  logic        stallreq, addr_err;

  int errors = 0;
  int checks = 0;

  mem_stage_if bus_if ();

  mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_op(ex_op), .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
    .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_wreg(ex_wreg),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_wspreg(ex_wspreg),
    .ex_wcp0(ex_wcp0), .ex_cp0_waddr(ex_cp0_waddr), .ex_cp0_wdata(ex_cp0_wdata),
    .llbit_i(llbit_i), .wb_watomicreg(wb_watomicreg),
    .wb_atomicreg_wdata(wb_atomicreg_wdata), .stall_i(stall_i),
    .bus(bus_if.master),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wreg(mem_wreg),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_wspreg(mem_wspreg),
    .mem_watomicreg(mem_watomicreg), .mem_atomicreg_wdata(mem_atomicreg_wdata),
    .mem_wcp0(mem_wcp0), .mem_cp0_waddr(mem_cp0_waddr), .mem_cp0_wdata(mem_cp0_wdata),
    .stallreq(stallreq), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic set_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd);
    ex_op         = op;
    ex_mem_addr   = addr;
    ex_store_data = sd;
  endtask

  task automatic bus_resp(input logic [31:0] rdata, input logic ack);
    bus_if.bus_rdata = rdata;
    bus_if.bus_ack   = ack;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    set_op(4'd5, 32'h0000_0100, 32'h0);
    bus_resp(32'h1234_5678, 1'b1);
    #1;
    checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus_if.bus_req); end
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL reset_stallreq: got %b want 0", stallreq); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
    checks++; if (mem_hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", mem_hi); end
    checks++; if (mem_wreg !== 1'b0) begin errors++; $display("FAIL reset_wreg: got %b want 0", mem_wreg); end
    @(negedge clk);
    rst = 1'b0;
    set_op(4'd0, 32'h0, 32'h0);
    bus_resp(32'h0, 1'b0);
    stall_i = 6'b111111;
    #1;
    checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL idle_none_req: got %b want 0", bus_if.bus_req); end
    checks++; if (mem_cp0_wdata !== 32'h3333_4444) begin errors++; $display("FAIL pass_cp0: got %h want 33334444", mem_cp0_wdata); end
    stall_i = 6'b0;
  endtask

  task automatic test_lb_zero_wait();
    @(negedge clk);
    set_op(4'd1, 32'h0000_1003, 32'h0);
    bus_resp(32'h1122_33F0, 1'b1);
    #1;
    checks++; if (bus_if.bus_sel !== 4'b0001) begin errors++; $display("FAIL lb_sel: got %b want 0001", bus_if.bus_sel); end
    checks++; if (bus_if.bus_addr !== 32'h0000_1000) begin errors++; $display("FAIL lb_addr: got %h want 00001000", bus_if.bus_addr); end
    checks++; if (mem_wdata !== 32'hFFFF_FFF0) begin errors++; $display("FAIL lb_data: got %h want fffffff0", mem_wdata); end
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL lb_stallreq: got %b want 0", stallreq); end
    @(negedge clk);
    set_op(4'd3, 32'h0000_1000, 32'h0);
    bus_resp(32'h8001_7777, 1'b1);
    #1;
    checks++; if (mem_wdata !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_data: got %h want ffff8001", mem_wdata); end
    @(negedge clk);
    set_op(4'd0, 32'h0, 32'h0);
    bus_resp(32'h0, 1'b0);
  endtask

  task automatic test_lhu_wait3();
    int stall_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) set_op(4'd4, 32'h0000_2002, 32'h0);
      if (c == 3) begin
        bus_resp(32'hAAAA_8001, 1'b1);
        stall_i = 6'b0;
      end else begin
        bus_resp(32'h0, 1'b0);
        stall_i = 6'b011111;
      end
      #1;
      if (stallreq === 1'b1) stall_cnt++;
      if (c == 2) begin
        checks++; if (bus_if.bus_addr !== 32'h0000_2000) begin errors++; $display("FAIL lhu_addr_hold: got %h want 00002000", bus_if.bus_addr); end
      end
      if (c == 3) begin
        checks++; if (bus_if.bus_sel !== 4'b0011) begin errors++; $display("FAIL lhu_sel: got %b want 0011", bus_if.bus_sel); end
        checks++; if (mem_wdata !== 32'h0000_8001) begin errors++; $display("FAIL lhu_data: got %h want 00008001", mem_wdata); end
      end
    end
    checks++; if (stall_cnt != 3) begin errors++; $display("FAIL lhu_stall_cycles: got %0d want 3", stall_cnt); end
    @(negedge clk);
    set_op(4'd0, 32'h0, 32'h0);
    bus_resp(32'h0, 1'b0);
    #1;
    checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL lhu_back_idle: got %b want 0", bus_if.bus_req); end
  endtask

  task automatic test_stores();
    @(negedge clk);
    set_op(4'd6, 32'h0000_3001, 32'h0000_00AB);
    bus_resp(32'h0, 1'b1);
    #1;
    checks++; if (bus_if.bus_we !== 1'b1) begin errors++; $display("FAIL sb_we: got %b want 1", bus_if.bus_we); end
    checks++; if (bus_if.bus_sel !== 4'b0100) begin errors++; $display("FAIL sb_sel: got %b want 0100", bus_if.bus_sel); end
    checks++; if (bus_if.bus_wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata: got %h want abababab", bus_if.bus_wdata); end
    checks++; if (mem_wreg !== 1'b1) begin errors++; $display("FAIL sb_wreg: got %b want 1", mem_wreg); end
    checks++; if (mem_wdata !== 32'h1111_2222) begin errors++; $display("FAIL sb_pass_wdata: got %h want 11112222", mem_wdata); end
    @(negedge clk);
    set_op(4'd7, 32'h0000_3002, 32'h5555_1234);
    #1;
    checks++; if (bus_if.bus_wdata !== 32'h1234_1234) begin errors++; $display("FAIL sh_wdata: got %h want 12341234", bus_if.bus_wdata); end
    checks++; if (bus_if.bus_sel !== 4'b0011) begin errors++; $display("FAIL sh_sel: got %b want 0011", bus_if.bus_sel); end
    @(negedge clk);
    set_op(4'd0, 32'h0, 32'h0);
    bus_resp(32'h0, 1'b0);
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    set_op(4'd5, 32'h0000_4002, 32'h0);
    bus_resp(32'h0, 1'b0);
    #1;
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL lw_mis_err: got %b want 1", addr_err); end
    checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL lw_mis_req: got %b want 0", bus_if.bus_req); end
    checks++; if (mem_wreg !== 1'b0) begin errors++; $display("FAIL lw_mis_wreg: got %b want 0", mem_wreg); end
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL lw_mis_stall: got %b want 0", stallreq); end
    checks++; if (mem_hi !== 32'hAAAA_0000) begin errors++; $display("FAIL lw_mis_hi: got %h want aaaa0000", mem_hi); end
    @(negedge clk);
    set_op(4'd7, 32'h0000_4001, 32'h0);
    #1;
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL sh_mis_err: got %b want 1", addr_err); end
    @(negedge clk);
    set_op(4'd0, 32'h0, 32'h0);
  endtask

  task automatic test_ll_sc();
    @(negedge clk);
    set_op(4'd9, 32'h0000_5000, 32'h0);
    bus_resp(32'hDEAD_BEEF, 1'b1);
    #1;
    checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ll_data: got %h want deadbeef", mem_wdata); end
    checks++; if ({mem_watomicreg, mem_atomicreg_wdata} !== 2'b11) begin errors++; $display("FAIL ll_link: got %b want 11", {mem_watomicreg, mem_atomicreg_wdata}); end
    @(negedge clk);
    set_op(4'd10, 32'h0000_5000, 32'h0000_0055);
    wb_watomicreg = 1'b1; wb_atomicreg_wdata = 1'b1; llbit_i = 1'b0;
    bus_resp(32'h0, 1'b1);
    #1;
    checks++; if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_sel} !== 6'b111111) begin errors++; $display("FAIL sc_ok_bus: got %b want 111111", {bus_if.bus_req, bus_if.bus_we, bus_if.bus_sel}); end
    checks++; if (bus_if.bus_wdata !== 32'h0000_0055) begin errors++; $display("FAIL sc_ok_wdata: got %h want 00000055", bus_if.bus_wdata); end
    checks++; if (mem_wdata !== 32'h1) begin errors++; $display("FAIL sc_ok_result: got %h want 1", mem_wdata); end
    checks++; if ({mem_watomicreg, mem_atomicreg_wdata} !== 2'b10) begin errors++; $display("FAIL sc_ok_link: got %b want 10", {mem_watomicreg, mem_atomicreg_wdata}); end
    @(negedge clk);
    wb_watomicreg = 1'b1; wb_atomicreg_wdata = 1'b0; llbit_i = 1'b1;
    bus_resp(32'h0, 1'b0);
    #1;
    checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL sc_fail_req: got %b want 0", bus_if.bus_req); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL sc_fail_result: got %h want 0", mem_wdata); end
    checks++; if (mem_watomicreg !== 1'b0) begin errors++; $display("FAIL sc_fail_link: got %b want 0", mem_watomicreg); end
    @(negedge clk);
    set_op(4'd0, 32'h0, 32'h0);
    wb_watomicreg = 1'b0; wb_atomicreg_wdata = 1'b0; llbit_i = 1'b0;
  endtask

  task automatic test_done_hold_and_reset();
    @(negedge clk);
    set_op(4'd5, 32'h0000_6000, 32'h0);
    bus_resp(32'hCAFE_F00D, 1'b1);
    stall_i = 6'b011111;
    #1;
    checks++; if (mem_wdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL done_ack_data: got %h want cafef00d", mem_wdata); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus_resp(32'h0, 1'b0);
      stall_i = (c == 2) ? 6'b0 : 6'b011111;
      #1;
      checks++; if (mem_wdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL done_hold_data c%0d: got %h want cafef00d", c, mem_wdata); end
      checks++; if ({bus_if.bus_req, stallreq} !== 2'b00) begin errors++; $display("FAIL done_hold_req c%0d: got %b want 00", c, {bus_if.bus_req, stallreq}); end
    end
    @(negedge clk);
    set_op(4'd0, 32'h0, 32'h0);
    #1;
    checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL done_exit: got %b want 0", bus_if.bus_req); end
    @(negedge clk);
    set_op(4'd5, 32'h0000_7000, 32'h0);
    @(negedge clk);
    #1;
    checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL wait_stallreq: got %b want 1", stallreq); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({bus_if.bus_req, stallreq, addr_err, mem_wreg, mem_wspreg, mem_wcp0} !== 6'b0) begin errors++; $display("FAIL rst_wait_flags: got %b want 000000", {bus_if.bus_req, stallreq, addr_err, mem_wreg, mem_wspreg, mem_wcp0}); end
    checks++; if ((bus_if.bus_addr | mem_wdata | mem_lo | mem_cp0_wdata) !== 32'h0) begin errors++; $display("FAIL rst_wait_data: got %h want 0", bus_if.bus_addr | mem_wdata | mem_lo | mem_cp0_wdata); end
    @(negedge clk);
    rst = 1'b0;
    set_op(4'd0, 32'h0, 32'h0);
    #1;
    checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL rst_to_idle: got %b want 0", bus_if.bus_req); end
  endtask

  initial begin
    rst = 1'b1;
    ex_waddr = 5'd7;       ex_wdata = 32'h1111_2222; ex_wreg = 1'b1;
    ex_hi = 32'hAAAA_0000; ex_lo = 32'h0000_BBBB;    ex_wspreg = 1'b1;
    ex_wcp0 = 1'b1;        ex_cp0_waddr = 5'd12;     ex_cp0_wdata = 32'h3333_4444;
    llbit_i = 1'b0; wb_watomicreg = 1'b0; wb_atomicreg_wdata = 1'b0;
    stall_i = 6'b0;
    set_op(4'd0, 32'h0, 32'h0);
    bus_resp(32'h0, 1'b0);
    test_reset();
    test_lb_zero_wait();
    test_lhu_wait3();
    test_stores();
    test_misaligned();
    test_ll_sc();
    test_done_hold_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between the EX/MEM register and the MEM/WB register. It executes loads, stores, LL and SC against a single-port data bus with a req/ack handshake. It extracts and extends load data and resolves the LL/SC link bit. It raises a stall request while a bus access is outstanding. All other EX results pass through unchanged to the MEM/WB register inputs.

## Interface
- No parameters; data width 32, register address width 5.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ex_op` in 4: memory op. 0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, 9 LL, 10 SC; others treated as NONE.
- `ex_mem_addr` in 32: effective address.
- `ex_store_data` in 32: store source (rt).
- `ex_waddr` in 5, `ex_wdata` in 32, `ex_wreg` in 1: GPR write from EX.
- `ex_hi`, `ex_lo` in 32, `ex_wspreg` in 1: HI/LO write.
- `ex_wcp0` in 1, `ex_cp0_waddr` in 5, `ex_cp0_wdata` in 32: CP0 write.
- `llbit_i` in 1: committed LLbit.
- `wb_watomicreg` in 1, `wb_atomicreg_wdata` in 1: LLbit write in WB, forwarded.
- `stall_i` in 6: pipeline stall vector; bit 4 = MEM stage held.
- `bus_req` out 1, `bus_we` out 1, `bus_addr` out 32 (word-aligned), `bus_sel` out 4, `bus_wdata` out 32.
- `bus_rdata` in 32, `bus_ack` in 1.
- `mem_waddr` out 5, `mem_wdata` out 32, `mem_wreg` out 1, `mem_hi` out 32, `mem_lo` out 32, `mem_wspreg` out 1, `mem_watomicreg` out 1, `mem_atomicreg_wdata` out 1, `mem_wcp0` out 1, `mem_cp0_waddr` out 5, `mem_cp0_wdata` out 32: to MEM/WB.
- `stallreq` out 1: request to hold IF..MEM.
- `addr_err` out 1: misaligned access flag.

## Operation
- FSM states:
  - IDLE: no access or first cycle of one.
  - WAIT: request issued, no ack yet.
  - DONE: access complete, result held because MEM is stalled by a later stage.
- Byte lanes are big-endian:
  - addr[1:0]=00 selects bits 31:24, sel 1000; 11 selects 7:0, sel 0001.
  - Halfword: addr[1]=0 gives sel 1100, else 0011. Word: sel 1111.
- Store data is replicated across lanes: byte ×4, half ×2.
- Misalignment (addr_err=1): LH/LHU/SH with addr[0]=1, or LW/SW/LL/SC with addr[1:0]≠0.
  - No bus request is made.
  - mem_wreg=0, mem_watomicreg=0; all other pass-through fields unchanged.
- Load results:
  - LB and LH sign-extend the selected lane.
  - LBU and LHU zero-extend.
  - LW and LL take the full word.
- mem_wdata = load result for loads, ex_wdata otherwise.
- Effective link bit = wb_watomicreg ? wb_atomicreg_wdata : llbit_i.
- LL: mem_watomicreg=1, mem_atomicreg_wdata=1.
- SC with link bit = 1:
  - Perform word store.
  - mem_wdata=1, mem_wreg=ex_wreg.
  - mem_watomicreg=1, mem_atomicreg_wdata=0.
- SC with link bit = 0:
  - No bus access.
  - mem_wdata=0, mem_watomicreg=0.
- Other ops: mem_watomicreg=0.
- All non-memory fields pass straight through: hi, lo, wspreg, cp0 fields, waddr.

## Timing
- Outputs are combinational from the inputs and FSM state. The only registers are the FSM state and a 32-bit captured read word.
- Bus rules:
  - bus_req asserts in IDLE (for an aligned access needing the bus) and in WAIT.
  - addr, we, sel and wdata stay stable until the ack cycle.
  - bus_ack is a one-cycle pulse, valid in the same cycle as req; this is the zero-wait case.
- stallreq = bus_req & ~bus_ack.
- State transitions:
  - IDLE, access, no ack → WAIT.
  - IDLE or WAIT, ack, stall_i[4]=0 → IDLE; result uses bus_rdata directly.
  - IDLE or WAIT, ack, stall_i[4]=1 → DONE; bus_rdata is captured.
  - DONE: bus_req=0, stallreq=0, load result from the captured word. Leave for IDLE when stall_i[4]=0.
- Latency:
  - Zero-wait memory: zero stall cycles.
  - N-cycle ack delay: stallreq high for N cycles.
- Reset:
  - While rst=1, every output is 0: bus_req, stallreq, addr_err, all mem_* fields, bus_* drives.
  - State → IDLE on the next edge, including mid-WAIT; the pending ack is dropped.
  - Captured word → 0.
- In IDLE with ex_op=NONE, bus_req stays 0 regardless of stall_i.

## Test plan
- LB at 0x1003, bus_rdata 0x112233F0, ack same cycle: sel=0001, mem_wdata=0xFFFFFFF0, stallreq never high.
- LHU at 0x2002, rdata 0xAAAA8001, ack after 3 cycles: stallreq high exactly 3 cycles, mem_wdata=0x00008001.
- SB at 0x3001, store 0x000000AB: bus_we=1, sel=0100, bus_wdata=0xABABABAB, mem_wreg=ex_wreg.
- LW at 0x4002: addr_err=1, bus_req=0, mem_wreg=0, stallreq=0.
- LL then SC:
  - wb_watomicreg=1 with data 1 and llbit_i=0: SC stores, mem_wdata=1, mem_atomicreg_wdata=0.
  - Repeat with link bit 0: no bus access, mem_wdata=0.
- Ack while stall_i[4]=1 → DONE, result held stable for 2 cycles; then rst asserted in WAIT on a fresh access: all outputs 0, next state IDLE.
